// File: rtl/dcache_controller_param.sv
// Write-back, write-allocate controller for a parametrised direct-mapped L1 D-cache.
// Define DCACHE_WBUF_EN to build in a one-entry victim write buffer that drains from IDLE.
module dcache_controller_param #(
    parameter int ADDR_W      = 20,
    parameter int SET_W       = 5,
    parameter int WORD_BYTES  = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        ren,
    input  logic                                        wen,
    input  logic [ADDR_W-1:0]                           addr,
    input  logic [WORD_BYTES-1:0]                       byteSelectVector,
    input  logic [8*WORD_BYTES-1:0]                     din,
    input  logic                                        cacheHit,
    input  logic                                        cacheDirtyBit,
    input  logic [ADDR_W-SET_W-$clog2(WORD_BYTES*BLOCK_WORDS)-1:0] cacheVictimTag,
    input  logic [8*WORD_BYTES*BLOCK_WORDS-1:0]         cacheDout,
    input  logic                                        memReadReady,
    input  logic                                        memWriteDone,
    input  logic [8*WORD_BYTES*BLOCK_WORDS-1:0]         memDout,
    output logic                                        stall,
    output logic [8*WORD_BYTES-1:0]                     dout,
    output logic                                        cacheEn,
    output logic                                        cacheWen,
    output logic                                        cacheMemWen,
    output logic [WORD_BYTES*BLOCK_WORDS-1:0]           cacheBytesAccess,
    output logic [8*WORD_BYTES*BLOCK_WORDS-1:0]         cacheDin,
    output logic                                        memRen,
    output logic                                        memWen,
    output logic [ADDR_W-$clog2(WORD_BYTES*BLOCK_WORDS)-1:0] memBlockAddr,
    output logic [8*WORD_BYTES*BLOCK_WORDS-1:0]         memDin
);

    localparam int WB       = 8 * WORD_BYTES;
    localparam int BB       = WORD_BYTES * BLOCK_WORDS;
    localparam int BLK_BITS = 8 * BB;
    localparam int OFF_W    = $clog2(BB);
    localparam int WOFF_W   = $clog2(BLOCK_WORDS);
    localparam int TAG_W    = ADDR_W - SET_W - OFF_W;
    localparam int BA_W     = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        FILL
    } state_t;

    state_t stateQ, stateD;

    logic [BA_W-1:0]       reqBlock;
    logic [WOFF_W-1:0]     reqWordOff;
    logic [WB-1:0]         reqDin;
    logic [WORD_BYTES-1:0] reqBsv;
    logic                  reqStore;
    logic [BA_W-1:0]       vicAddr;
    logic [BLK_BITS-1:0]   vicBlock;
    logic [BLK_BITS-1:0]   fillBlock;

    logic                  latchReq;
    logic [WOFF_W-1:0]     wordOff;
    logic [SET_W-1:0]      setIdx;
    logic                  req;
    logic [BB-1:0]         mergeMask;
    logic [BLK_BITS-1:0]   mergedBlock;
    logic [BLK_BITS-1:0]   reqDinRep;
    logic                  unusedAddr;

`ifdef DCACHE_WBUF_EN
    logic wbValid;
    logic wbLoad;
    logic wbClear;
`endif

    assign wordOff    = addr[OFF_W-1 -: WOFF_W];
    assign setIdx     = addr[OFF_W +: SET_W];
    assign req        = ren | wen;
    assign unusedAddr = ^addr;

    function automatic logic [BB-1:0] byteMask(input logic [WORD_BYTES-1:0] bsv,
                                               input logic [WOFF_W-1:0] wOff);
        logic [BB-1:0] m;
        m = '0;
        m[WORD_BYTES-1:0] = bsv;
        return m << (int'(wOff) * WORD_BYTES);
    endfunction

    // Store bytes of a write-allocate miss overwrite the refilled block in the fill cycle.
    always_comb begin
        mergeMask   = reqStore ? byteMask(reqBsv, reqWordOff) : '0;
        reqDinRep   = {BLOCK_WORDS{reqDin}};
        mergedBlock = fillBlock;
        for (int unsigned b = 0; b < BB; b++) begin
            if (mergeMask[b]) begin
                mergedBlock[8*b +: 8] = reqDinRep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ     <= IDLE;
            reqBlock   <= '0;
            reqWordOff <= '0;
            reqDin     <= '0;
            reqBsv     <= '0;
            reqStore   <= 1'b0;
            vicAddr    <= '0;
            vicBlock   <= '0;
            fillBlock  <= '0;
`ifdef DCACHE_WBUF_EN
            wbValid    <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            if (latchReq) begin
                reqBlock   <= addr[ADDR_W-1:OFF_W];
                reqWordOff <= wordOff;
                reqDin     <= din;
                reqBsv     <= byteSelectVector;
                reqStore   <= wen;
                if (cacheDirtyBit) begin
                    vicAddr  <= {cacheVictimTag, setIdx};
                    vicBlock <= cacheDout;
                end
            end
            if (stateQ == REFILL && memReadReady) begin
                fillBlock <= memDout;
            end
`ifdef DCACHE_WBUF_EN
            if (wbLoad) begin
                wbValid <= 1'b1;
            end else if (wbClear) begin
                wbValid <= 1'b0;
            end
`endif
        end
    end

    always_comb begin
        stateD           = stateQ;
        latchReq         = 1'b0;
        stall            = 1'b0;
        dout             = '0;
        cacheEn          = 1'b0;
        cacheWen         = 1'b0;
        cacheMemWen      = 1'b0;
        cacheBytesAccess = '0;
        cacheDin         = '0;
        memRen           = 1'b0;
        memWen           = 1'b0;
        memBlockAddr     = '0;
        memDin           = '0;
`ifdef DCACHE_WBUF_EN
        wbLoad           = 1'b0;
        wbClear          = 1'b0;
`endif
        if (!reset) begin
            case (stateQ)
                IDLE: begin
                    cacheEn = req;
`ifdef DCACHE_WBUF_EN
                    // Drain runs under hits; a full buffer blocks every miss, which also
                    // covers a miss to the buffered block.
                    if (wbValid) begin
                        memWen       = 1'b1;
                        memBlockAddr = vicAddr;
                        memDin       = vicBlock;
                        wbClear      = memWriteDone;
                    end
`endif
                    if (req && cacheHit) begin
                        if (wen) begin
                            cacheWen         = 1'b1;
                            cacheBytesAccess = byteMask(byteSelectVector, wordOff);
                            cacheDin         = {BLOCK_WORDS{din}};
                        end else begin
                            dout = cacheDout[int'(wordOff)*WB +: WB];
                        end
                    end else if (req) begin
                        stall = 1'b1;
`ifdef DCACHE_WBUF_EN
                        if (!wbValid) begin
                            latchReq = 1'b1;
                            wbLoad   = cacheDirtyBit;
                            stateD   = REFILL;
                        end
`else
                        latchReq = 1'b1;
                        stateD   = cacheDirtyBit ? WRITEBACK : REFILL;
`endif
                    end
                end
                WRITEBACK: begin
                    stall        = 1'b1;
                    memWen       = 1'b1;
                    memBlockAddr = vicAddr;
                    memDin       = vicBlock;
                    if (memWriteDone) begin
                        stateD = REFILL;
                    end
                end
                REFILL: begin
                    stall        = 1'b1;
                    memRen       = 1'b1;
                    memBlockAddr = reqBlock;
                    if (memReadReady) begin
                        stateD = FILL;
                    end
                end
                FILL: begin
                    stall            = 1'b1;
                    cacheEn          = 1'b1;
                    cacheMemWen      = 1'b1;
                    cacheBytesAccess = '1;
                    cacheDin         = mergedBlock;
                    stateD           = IDLE;
                end
                default: stateD = IDLE;
            endcase
        end
    end

endmodule
